// File: rtl/alu_seq_divider.sv
// Radix-2 restoring divider, one quotient bit per cycle, signed or unsigned.
// Signed operands are divided as magnitudes and the signs are reapplied in FIX.
module alu_seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX,
        DONE
    } state_t;

    state_t           state_reg;
    logic [CW-1:0]    count_reg;
    logic [WIDTH-1:0] rem_reg;
    logic [WIDTH-1:0] dvd_reg;
    logic [WIDTH-1:0] dvs_reg;
    logic             neg_q_reg;
    logic             neg_r_reg;

    logic [WIDTH-1:0] dividend_abs;
    logic [WIDTH-1:0] divisor_abs;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;
    logic             trial_ok;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] dvd_next;

    // Negating -2^(W-1) yields 2^(W-1), which is exactly its unsigned magnitude.
    assign dividend_abs = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
    assign divisor_abs  = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;

    // The shifted remainder can reach 2*divisor-1, so it needs one extra bit;
    // a further bit holds the borrow of the trial subtraction.
    assign shifted  = {rem_reg, dvd_reg[WIDTH-1]};
    assign diff     = {1'b0, shifted} - {2'b00, dvs_reg};
    assign trial_ok = ~diff[WIDTH+1];
    assign rem_next = trial_ok ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign dvd_next = {dvd_reg[WIDTH-2:0], trial_ok};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            count_reg   <= '0;
            rem_reg     <= '0;
            dvd_reg     <= '0;
            dvs_reg     <= '0;
            neg_q_reg   <= 1'b0;
            neg_r_reg   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    if (start) begin
                        busy <= 1'b1;
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                            state_reg   <= DONE;
                        end else begin
                            div_by_zero <= 1'b0;
                            rem_reg     <= '0;
                            dvd_reg     <= dividend_abs;
                            dvs_reg     <= divisor_abs;
                            neg_q_reg   <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                            neg_r_reg   <= is_signed & dividend[WIDTH-1];
                            count_reg   <= CW'(WIDTH);
                            state_reg   <= RUN;
                        end
                    end
                end
                RUN: begin
                    // dvd_reg fills with quotient bits from the right as the dividend shifts out.
                    rem_reg   <= rem_next;
                    dvd_reg   <= dvd_next;
                    count_reg <= count_reg - CW'(1);
                    if (count_reg == CW'(1)) begin
                        state_reg <= FIX;
                    end
                end
                FIX: begin
                    quotient  <= neg_q_reg ? -dvd_reg : dvd_reg;
                    remainder <= neg_r_reg ? -rem_reg : rem_reg;
                    done      <= 1'b1;
                    state_reg <= DONE;
                end
                DONE: begin
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_divider.sv
// Self-checking bench for alu_seq_divider: directed corner cases plus random
// operands checked against a plain-arithmetic model of integer division.
module tb_alu_seq_divider;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         is_signed = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_seq_divider #(.WIDTH(W)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .is_signed(is_signed),
        .dividend(dividend),
        .divisor(divisor),
        .busy(busy),
        .done(done),
        .quotient(quotient),
        .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    // Reference: truncating division, remainder takes the dividend's sign.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic dz, output int lat);
        longint sa;
        longint sb;
        if (b == '0) begin
            q   = '1;
            r   = a;
            dz  = 1'b1;
            lat = 1;
        end else begin
            dz  = 1'b0;
            lat = W + 2;
            if (s) begin
                sa = $signed(a);
                sb = $signed(b);
                q  = 32'(sa / sb);
                r  = 32'(sa % sb);
            end else begin
                q = a / b;
                r = a % b;
            end
        end
    endfunction

    // Issues one request, scrambles operands after accept, and reports the
    // edge (counted from accept) at which done is first sampled high.
    task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          output logic [W-1:0] q, output logic [W-1:0] r,
                          output logic dz, output int lat, output logic to);
        @(negedge clk);
        start     = 1'b1;
        dividend  = a;
        divisor   = b;
        is_signed = s;
        @(posedge clk);
        #1;
        start     = 1'b0;
        dividend  = $urandom;
        divisor   = $urandom;
        is_signed = 1'($urandom_range(0, 1));
        lat = 0;
        for (int j = 0; j < 200; j++) begin
            @(negedge clk);
            if (done) begin
                lat = j + 1;
                break;
            end
        end
        to = (lat == 0);
        q  = quotient;
        r  = remainder;
        dz = div_by_zero;
        $display("txn %h / %h signed=%0d -> q=%h r=%h dz=%0d lat=%0d", a, b, s, q, r, dz, lat);
    endtask

    task automatic test_reset();
        start    = 1'b1;
        dividend = 32'd9;
        divisor  = 32'd0;
        rst      = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({busy, done, div_by_zero} !== 3'b000 || quotient !== '0 || remainder !== '0) begin
            n_err++;
            $display("FAIL reset: busy=%b done=%b dz=%b q=%h r=%h, required all zero",
                     busy, done, div_by_zero, quotient, remainder);
        end
        start = 1'b0;
        rst   = 1'b0;
    endtask

    task automatic test_directed();
        logic [W-1:0] q, r;
        logic dz, to;
        int lat;
        logic [W-1:0] ta [4];
        logic [W-1:0] tb [4];
        logic         ts [4];
        logic [W-1:0] eq [4];
        logic [W-1:0] er [4];
        logic         ed [4];
        int           el [4];
        ta = '{32'd100, -32'sd100, 32'h8000_0000, 32'd5};
        tb = '{32'd7, 32'd7, 32'hFFFF_FFFF, 32'd0};
        ts = '{1'b0, 1'b1, 1'b1, 1'b0};
        eq = '{32'd14, 32'hFFFF_FFF2, 32'h8000_0000, 32'hFFFF_FFFF};
        er = '{32'd2, 32'hFFFF_FFFE, 32'd0, 32'd5};
        ed = '{1'b0, 1'b0, 1'b0, 1'b1};
        el = '{34, 34, 34, 1};
        for (int i = 0; i < 4; i++) begin
            do_div(ta[i], tb[i], ts[i], q, r, dz, lat, to);
            n_vec++;
            if (to) begin
                n_err++;
                $display("FAIL directed%0d_timeout: no done within 200 cycles, required done", i);
            end
            n_vec++;
            if (q !== eq[i]) begin
                n_err++;
                $display("FAIL directed%0d_quotient: got %h, required %h", i, q, eq[i]);
            end
            n_vec++;
            if (r !== er[i]) begin
                n_err++;
                $display("FAIL directed%0d_remainder: got %h, required %h", i, r, er[i]);
            end
            n_vec++;
            if (dz !== ed[i]) begin
                n_err++;
                $display("FAIL directed%0d_dbz: got %b, required %b", i, dz, ed[i]);
            end
            n_vec++;
            if (lat != el[i]) begin
                n_err++;
                $display("FAIL directed%0d_latency: got %0d, required %0d", i, lat, el[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, q, r, mq, mr;
        logic s, dz, mdz, to;
        int lat, mlat, sel;
        for (int i = 0; i < 40; i++) begin
            s   = 1'($urandom_range(0, 1));
            sel = $urandom_range(0, 9);
            a   = $urandom;
            case (sel)
                0: b = '0;
                1: b = 32'($urandom_range(1, 15));
                2: begin
                    a = 32'h8000_0000;
                    b = '1;
                end
                3: b = a;
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            model(a, b, s, mq, mr, mdz, mlat);
            do_div(a, b, s, q, r, dz, lat, to);
            n_vec++;
            if (to || lat != mlat) begin
                n_err++;
                $display("FAIL rand%0d_latency: got %0d, required %0d", i, lat, mlat);
            end
            n_vec++;
            if (q !== mq) begin
                n_err++;
                $display("FAIL rand%0d_quotient: %h/%h s=%0d got %h, required %h", i, a, b, s, q, mq);
            end
            n_vec++;
            if (r !== mr) begin
                n_err++;
                $display("FAIL rand%0d_remainder: %h/%h s=%0d got %h, required %h", i, a, b, s, r, mr);
            end
            n_vec++;
            if (dz !== mdz) begin
                n_err++;
                $display("FAIL rand%0d_dbz: got %b, required %b", i, dz, mdz);
            end
        end
    endtask

    task automatic test_busy_ignore();
        int seen;
        @(negedge clk);
        start     = 1'b1;
        dividend  = 32'd100;
        divisor   = 32'd7;
        is_signed = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        start    = 1'b1;
        dividend = 32'd55;
        divisor  = 32'd0;
        @(negedge clk);
        start = 1'b0;
        seen  = 0;
        for (int j = 0; j < 100; j++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                break;
            end
        end
        n_vec++;
        if (seen != 1 || quotient !== 32'd14 || remainder !== 32'd2 || div_by_zero !== 1'b0) begin
            n_err++;
            $display("FAIL busy_ignore_result: done=%0d q=%h r=%h dz=%b, required done q=0000000e r=00000002 dz=0",
                     seen, quotient, remainder, div_by_zero);
        end
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0 || quotient !== 32'd14) begin
            n_err++;
            $display("FAIL busy_ignore_idle: busy=%b done=%b q=%h, required busy=0 done=0 q=0000000e",
                     busy, done, quotient);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] q, r;
        logic dz, to;
        int lat;
        do_div(32'd1000, 32'd10, 1'b0, q, r, dz, lat, to);
        n_vec++;
        if (to || q !== 32'd100 || r !== 32'd0) begin
            n_err++;
            $display("FAIL b2b_first: q=%h r=%h timeout=%b, required q=00000064 r=00000000", q, r, to);
        end
        // Start held from the DONE cycle: only the following IDLE cycle may accept it.
        start     = 1'b1;
        dividend  = 32'd77;
        divisor   = 32'd0;
        is_signed = 1'b0;
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0 || quotient !== 32'd100) begin
            n_err++;
            $display("FAIL b2b_done_cycle_start: busy=%b done=%b dz=%b q=%h, required 0 0 0 00000064",
                     busy, done, div_by_zero, quotient);
        end
        @(negedge clk);
        start = 1'b0;
        n_vec++;
        if (done !== 1'b1 || busy !== 1'b1 || div_by_zero !== 1'b1 || remainder !== 32'd77 || quotient !== '1) begin
            n_err++;
            $display("FAIL b2b_second: done=%b busy=%b dz=%b q=%h r=%h, required 1 1 1 ffffffff 0000004d",
                     done, busy, div_by_zero, quotient, remainder);
        end
    endtask

    task automatic test_mid_reset();
        logic [W-1:0] q, r;
        logic dz, to;
        int lat, seen;
        @(negedge clk);
        start     = 1'b1;
        dividend  = 32'd1000000;
        divisor   = 32'd3;
        is_signed = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_vec++;
        if ({busy, done, div_by_zero} !== 3'b000 || quotient !== '0 || remainder !== '0) begin
            n_err++;
            $display("FAIL mid_reset_outputs: busy=%b done=%b dz=%b q=%h r=%h, required all zero",
                     busy, done, div_by_zero, quotient, remainder);
        end
        seen = 0;
        for (int j = 0; j < 50; j++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        n_vec++;
        if (seen != 0) begin
            n_err++;
            $display("FAIL mid_reset_no_done: done pulsed %0d, required 0", seen);
        end
        do_div(32'hFFFF_FFFF, 32'd1, 1'b0, q, r, dz, lat, to);
        n_vec++;
        if (to || q !== 32'hFFFF_FFFF || r !== 32'd0 || dz !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset_fresh: q=%h r=%h dz=%b timeout=%b, required ffffffff 00000000 0 0",
                     q, r, dz, to);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_busy_ignore();
        test_back_to_back();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
